// File: rtl/fm_stim_pkg.sv
// fm_stim_pkg: shared types and default widths for the FM stimulus sequencer.
//   fm_stim_state_e : sequencer state encoding
//   fm_stim_entry_t : one table entry {freq, ampl, noise, dwell} at default widths
//   FM_ENTRY_W      : packed width of one table entry at default widths
package fm_stim_pkg;

   localparam int FM_DEPTH   = 16;
   localparam int FM_FREQ_W  = 32;
   localparam int FM_AMPL_W  = 16;
   localparam int FM_DWELL_W = 24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_FETCH = 3'd2,
      ST_OFFER = 3'd3,
      ST_DWELL = 3'd4
   } fm_stim_state_e;

   typedef struct packed {
      logic [FM_FREQ_W-1:0]  freq;
      logic [FM_AMPL_W-1:0]  ampl;
      logic [FM_AMPL_W-1:0]  noise;
      logic [FM_DWELL_W-1:0] dwell;
   } fm_stim_entry_t;

   localparam int FM_ENTRY_W = $bits(fm_stim_entry_t);

endpackage

// File: rtl/fm_stim_table.sv
// fm_stim_table: DEPTH-entry stimulus table, one write port, one registered read port.
//   clk, reset       : clock, async active-high reset (read register only)
//   we, wr_addr,     : write strobe, address and packed entry data
//   wr_data
//   rd_en, rd_addr   : read enable and address; rd_data updates only when rd_en=1
//   rd_data          : registered read data, held between reads
module fm_stim_table
   import fm_stim_pkg::*;
#(
   parameter int DEPTH  = FM_DEPTH,
   parameter int DATA_W = FM_ENTRY_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[wr_addr] <= wr_data;
   end

   // Read data is captured once per FETCH and held, so writes to the entry
   // being offered do not disturb the config seen by the generator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      rd_q <= '0;
      else if (rd_en) rd_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/fm_stim_sched.sv
// fm_stim_sched: steps a tone generator and its PRBS noise sources through a
// programmed table of (freq, ampl, noise, dwell) entries.
//   Table write : tbl_we, tbl_addr, tbl_freq/ampl/noise/dwell
//   Control     : n_steps (0 -> 1, >DEPTH -> DEPTH), start, abort, loop
//   Config      : cfg_valid/cfg_ready handshake, cfg_freq/ampl/noise
//   Status      : gen_en, noise_en, prbs_init, step, busy, done
// Build option FM_STIM_LOOP_EN: when defined, loop repeats the table after the
// last step; otherwise loop is ignored and every run is a single pass.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | one-cycle PRBS re-seed
// FETCH | registered table read at step
// OFFER | cfg_valid high until cfg_ready
// DWELL | hold entry for max(dwell,1) cycles
module fm_stim_sched
   import fm_stim_pkg::*;
#(
   parameter int DEPTH   = FM_DEPTH,
   parameter int FREQ_W  = FM_FREQ_W,
   parameter int AMPL_W  = FM_AMPL_W,
   parameter int DWELL_W = FM_DWELL_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tbl_we,
   input  logic [$clog2(DEPTH)-1:0]   tbl_addr,
   input  logic [FREQ_W-1:0]          tbl_freq,
   input  logic [AMPL_W-1:0]          tbl_ampl,
   input  logic [AMPL_W-1:0]          tbl_noise,
   input  logic [DWELL_W-1:0]         tbl_dwell,
   input  logic [$clog2(DEPTH):0]     n_steps,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       loop,
   output logic                       cfg_valid,
   input  logic                       cfg_ready,
   output logic [FREQ_W-1:0]          cfg_freq,
   output logic [AMPL_W-1:0]          cfg_ampl,
   output logic [AMPL_W-1:0]          cfg_noise,
   output logic                       gen_en,
   output logic                       noise_en,
   output logic                       prbs_init,
   output logic [$clog2(DEPTH)-1:0]   step,
   output logic                       busy,
   output logic                       done
);

   localparam int AW    = $clog2(DEPTH);
   localparam int NW    = AW + 1;
   localparam int ENT_W = FREQ_W + 2*AMPL_W + DWELL_W;

   fm_stim_state_e     state_q, state_d;
   logic [AW-1:0]      step_q, step_d;
   logic [NW-1:0]      n_q, n_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               gen_en_q, gen_en_d;
   logic               noise_en_q, noise_en_d;
   logic               done_q, done_d;
   logic               rd_en;

   logic [ENT_W-1:0]   rd_ent;
   logic [FREQ_W-1:0]  ent_freq;
   logic [AMPL_W-1:0]  ent_ampl;
   logic [AMPL_W-1:0]  ent_noise;
   logic [DWELL_W-1:0] ent_dwell;
   logic [NW-1:0]      n_clamped;
   logic               last_step;
   logic               loop_live;

`ifdef FM_STIM_LOOP_EN
   assign loop_live = loop;
`else
   logic unused_loop;
   assign unused_loop = loop;
   assign loop_live   = 1'b0;
`endif

   fm_stim_table #(
      .DEPTH  (DEPTH),
      .DATA_W (ENT_W)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .we      (tbl_we),
      .wr_addr (tbl_addr),
      .wr_data ({tbl_freq, tbl_ampl, tbl_noise, tbl_dwell}),
      .rd_en   (rd_en),
      .rd_addr (step_q),
      .rd_data (rd_ent)
   );

   assign {ent_freq, ent_ampl, ent_noise, ent_dwell} = rd_ent;

   always_comb begin
      n_clamped = n_steps;
      if (n_steps == '0)               n_clamped = NW'(1);
      else if (n_steps > NW'(DEPTH))   n_clamped = NW'(DEPTH);
   end

   assign last_step = ({1'b0, step_q} + NW'(1)) >= n_q;

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      gen_en_d   = gen_en_q;
      noise_en_d = noise_en_q;
      done_d     = 1'b0;
      rd_en      = 1'b0;
      if (abort) begin
         state_d    = ST_IDLE;
         gen_en_d   = 1'b0;
         noise_en_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_INIT;
                  n_d     = n_clamped;
                  step_d  = '0;
               end
            end
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: begin
               rd_en   = 1'b1;
               state_d = ST_OFFER;
            end
            ST_OFFER: begin
               if (cfg_ready) begin
                  state_d    = ST_DWELL;
                  gen_en_d   = 1'b1;
                  noise_en_d = (ent_noise != '0);
                  cnt_d      = (ent_dwell == '0) ? DWELL_W'(1) : ent_dwell;
               end
            end
            ST_DWELL: begin
               if (cnt_q <= DWELL_W'(1)) begin
                  if (!last_step) begin
                     step_d  = step_q + AW'(1);
                     state_d = ST_FETCH;
                  end else if (loop_live) begin
                     step_d  = '0;
                     state_d = ST_FETCH;
                  end else begin
                     state_d    = ST_IDLE;
                     done_d     = 1'b1;
                     gen_en_d   = 1'b0;
                     noise_en_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q - DWELL_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         step_q     <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         gen_en_q   <= 1'b0;
         noise_en_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         gen_en_q   <= gen_en_d;
         noise_en_q <= noise_en_d;
         done_q     <= done_d;
      end
   end

   assign cfg_valid = (state_q == ST_OFFER);
   assign cfg_freq  = ent_freq;
   assign cfg_ampl  = ent_ampl;
   assign cfg_noise = ent_noise;
   assign prbs_init = (state_q == ST_INIT);
   assign busy      = (state_q != ST_IDLE);
   assign step      = step_q;
   assign gen_en    = gen_en_q;
   assign noise_en  = noise_en_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fm_stim_sched.sv
// tb_fm_stim_sched: randomized self-checking bench for fm_stim_sched. A shadow
// copy of the table plus the step/pass/dwell rules give the expected config
// sequence and the exact cycle on which each output must change.
module tb_fm_stim_sched;

   localparam int DEPTH   = 16;
   localparam int FREQ_W  = 32;
   localparam int AMPL_W  = 16;
   localparam int DWELL_W = 24;

   logic              clk = 1'b0;
   logic              reset;
   logic              tbl_we;
   logic [3:0]        tbl_addr;
   logic [FREQ_W-1:0] tbl_freq;
   logic [AMPL_W-1:0] tbl_ampl;
   logic [AMPL_W-1:0] tbl_noise;
   logic [DWELL_W-1:0] tbl_dwell;
   logic [4:0]        n_steps;
   logic              start;
   logic              abort;
   logic              loop;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [FREQ_W-1:0] cfg_freq;
   logic [AMPL_W-1:0] cfg_ampl;
   logic [AMPL_W-1:0] cfg_noise;
   logic              gen_en;
   logic              noise_en;
   logic              prbs_init;
   logic [3:0]        step;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   fm_stim_sched #(
      .DEPTH   (DEPTH),
      .FREQ_W  (FREQ_W),
      .AMPL_W  (AMPL_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tbl_we    (tbl_we),
      .tbl_addr  (tbl_addr),
      .tbl_freq  (tbl_freq),
      .tbl_ampl  (tbl_ampl),
      .tbl_noise (tbl_noise),
      .tbl_dwell (tbl_dwell),
      .n_steps   (n_steps),
      .start     (start),
      .abort     (abort),
      .loop      (loop),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_freq  (cfg_freq),
      .cfg_ampl  (cfg_ampl),
      .cfg_noise (cfg_noise),
      .gen_en    (gen_en),
      .noise_en  (noise_en),
      .prbs_init (prbs_init),
      .step      (step),
      .busy      (busy),
      .done      (done)
   );

   int total = 0;
   int bad   = 0;

   logic [FREQ_W-1:0]  m_freq  [DEPTH];
   logic [AMPL_W-1:0]  m_ampl  [DEPTH];
   logic [AMPL_W-1:0]  m_noise [DEPTH];
   logic [DWELL_W-1:0] m_dwell [DEPTH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp_n(input int n);
      if (n == 0) return 1;
      if (n > DEPTH) return DEPTH;
      return n;
   endfunction

   function automatic logic [AMPL_W-1:0] rand_noise();
      logic [AMPL_W-1:0] v;
      v = ($urandom_range(1, 0) == 0) ? '0 : AMPL_W'($urandom);
      return v;
   endfunction

   task automatic tbl_write(input int a, input logic [FREQ_W-1:0] f, input logic [AMPL_W-1:0] am,
                            input logic [AMPL_W-1:0] no, input logic [DWELL_W-1:0] dw);
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = a[3:0];
      tbl_freq = f; tbl_ampl = am; tbl_noise = no; tbl_dwell = dw;
      @(negedge clk);
      tbl_we = 1'b0;
      m_freq[a] = f; m_ampl[a] = am; m_noise[a] = no; m_dwell[a] = dw;
   endtask

   // One complete run: nst programmed steps, passes requested via loop,
   // random ready back-pressure up to wmax cycles (w0 >= 0 forces the first wait).
   task automatic do_run(input int nst, input int passes, input int wmax, input int w0, input bit allow_wr);
      int n_eff, exp_passes, total_steps, s, d, w;
      logic [FREQ_W-1:0] e_freq;
      logic [AMPL_W-1:0] e_ampl, e_noise;
      logic [DWELL_W-1:0] e_dwell;
      bit exp_gen, exp_nen, last;
      n_eff = clamp_n(nst);
`ifdef FM_STIM_LOOP_EN
      exp_passes = passes;
`else
      exp_passes = 1;
`endif
      total_steps = n_eff * exp_passes;
      @(negedge clk);
      n_steps = nst[4:0];
      loop    = (passes > 1);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("init_busy",  64'(busy),      64'(1));
      chk("init_prbs",  64'(prbs_init), 64'(1));
      chk("init_valid", 64'(cfg_valid), 64'(0));
      @(posedge clk); #1;
      chk("fetch_prbs",  64'(prbs_init), 64'(0));
      chk("fetch_valid", 64'(cfg_valid), 64'(0));
      @(posedge clk); #1;
      exp_gen = 1'b0;
      exp_nen = 1'b0;
      for (int i = 0; i < total_steps; i++) begin
         s       = i % n_eff;
         last    = (i == total_steps - 1);
         e_freq  = m_freq[s];
         e_ampl  = m_ampl[s];
         e_noise = m_noise[s];
         e_dwell = m_dwell[s];
         d = (e_dwell == '0) ? 1 : int'(e_dwell);
         w = (i == 0 && w0 >= 0) ? w0 : int'($urandom_range(wmax, 0));
         chk("offer_valid",  64'(cfg_valid), 64'(1));
         chk("offer_step",   64'(step),      64'(s));
         chk("offer_freq",   64'(cfg_freq),  64'(e_freq));
         chk("offer_ampl",   64'(cfg_ampl),  64'(e_ampl));
         chk("offer_noise",  64'(cfg_noise), 64'(e_noise));
         chk("offer_prbs",   64'(prbs_init), 64'(0));
         chk("offer_gen",    64'(gen_en),    64'(exp_gen));
         chk("offer_nen",    64'(noise_en),  64'(exp_nen));
         for (int k = 0; k < w; k++) begin
            cfg_ready = 1'b0;
            if (allow_wr && k == 0) begin
               tbl_we = 1'b1; tbl_addr = s[3:0];
               tbl_freq = FREQ_W'($urandom); tbl_ampl = AMPL_W'($urandom);
               tbl_noise = rand_noise(); tbl_dwell = DWELL_W'($urandom_range(4, 0));
            end
            @(posedge clk); #1;
            if (tbl_we) begin
               m_freq[s] = tbl_freq; m_ampl[s] = tbl_ampl;
               m_noise[s] = tbl_noise; m_dwell[s] = tbl_dwell;
               tbl_we = 1'b0;
            end
            chk("hold_valid", 64'(cfg_valid), 64'(1));
            chk("hold_freq",  64'(cfg_freq),  64'(e_freq));
            chk("hold_noise", 64'(cfg_noise), 64'(e_noise));
            chk("hold_nen",   64'(noise_en),  64'(exp_nen));
         end
         cfg_ready = 1'b1;
         @(posedge clk); #1;
         cfg_ready = 1'b0;
         exp_gen = 1'b1;
         exp_nen = (e_noise != '0);
         chk("hs_gen",   64'(gen_en),    64'(1));
         chk("hs_nen",   64'(noise_en),  64'(exp_nen));
         chk("hs_valid", 64'(cfg_valid), 64'(0));
         if (last) loop = 1'b0;
         if ($urandom_range(1, 0) == 1) start = 1'b1;
         for (int k = 1; k < d; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("dwell_valid", 64'(cfg_valid), 64'(0));
            chk("dwell_busy",  64'(busy),      64'(1));
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (last) begin
            chk("done_pulse", 64'(done),      64'(1));
            chk("done_busy",  64'(busy),      64'(0));
            chk("done_gen",   64'(gen_en),    64'(0));
            chk("done_nen",   64'(noise_en),  64'(0));
            chk("done_valid", 64'(cfg_valid), 64'(0));
            @(posedge clk); #1;
            chk("done_once",  64'(done),      64'(0));
            chk("idle_busy",  64'(busy),      64'(0));
         end else begin
            chk("gap_valid", 64'(cfg_valid), 64'(0));
            chk("gap_gen",   64'(gen_en),    64'(1));
            chk("gap_done",  64'(done),      64'(0));
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic do_abort(input bit in_dwell);
      logic seen_done;
      @(negedge clk);
      n_steps = 5'd2; loop = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abrt_pre_valid", 64'(cfg_valid), 64'(1));
      if (in_dwell) begin
         cfg_ready = 1'b1;
         @(posedge clk); #1;
         cfg_ready = 1'b0;
         chk("abrt_pre_gen", 64'(gen_en), 64'(1));
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abrt_busy",  64'(busy),      64'(0));
      chk("abrt_valid", 64'(cfg_valid), 64'(0));
      chk("abrt_gen",   64'(gen_en),    64'(0));
      chk("abrt_nen",   64'(noise_en),  64'(0));
      seen_done = done;
      repeat (12) begin
         @(posedge clk); #1;
         seen_done = seen_done | done;
      end
      chk("abrt_nodone", 64'(seen_done), 64'(0));
      chk("abrt_idle",   64'(busy),      64'(0));
   endtask

   initial begin
      reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_freq = '0; tbl_ampl = '0;
      tbl_noise = '0; tbl_dwell = '0; n_steps = '0; start = 1'b0; abort = 1'b0;
      loop = 1'b0; cfg_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   64'(busy),      64'(0));
      chk("rst_valid",  64'(cfg_valid), 64'(0));
      chk("rst_gen",    64'(gen_en),    64'(0));
      chk("rst_nen",    64'(noise_en),  64'(0));
      chk("rst_prbs",   64'(prbs_init), 64'(0));
      chk("rst_done",   64'(done),      64'(0));
      chk("rst_step",   64'(step),      64'(0));
      chk("rst_freq",   64'(cfg_freq),  64'(0));
      @(negedge clk);
      reset = 1'b0;

      for (int a = 0; a < DEPTH; a++)
         tbl_write(a, FREQ_W'($urandom), AMPL_W'($urandom), rand_noise(),
                   DWELL_W'($urandom_range(6, 0)));
      tbl_write(0, 32'h0100_0000, 16'h1234, 16'h0000, 24'd10);
      tbl_write(1, 32'h0200_0000, 16'h2345, 16'h0100, 24'd0);
      tbl_write(2, 32'h0300_0000, 16'h3456, 16'h0042, 24'd5);

      do_run(3, 1, 0, 0, 1'b0);     // dwells 10/0/5, ready high
      do_run(3, 1, 2, 7, 1'b1);     // ready low 7 cycles on first offer
      do_run(2, 3, 1, -1, 1'b0);    // loop for three passes
      do_run(0, 1, 0, -1, 1'b0);    // n_steps=0 -> one step
      do_run(20, 1, 1, -1, 1'b1);   // n_steps=20 -> sixteen steps

      tbl_write(0, FREQ_W'($urandom), AMPL_W'($urandom), 16'h0100, 24'd8);
      do_abort(1'b1);
      do_abort(1'b0);

      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", 64'(busy),      64'(0));
      chk("sa_prbs", 64'(prbs_init), 64'(0));

      @(negedge clk);
      n_steps = 5'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cfg_ready = 1'b1;
      @(posedge clk); #1;
      cfg_ready = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("arst_busy", 64'(busy),     64'(0));
      chk("arst_gen",  64'(gen_en),   64'(0));
      chk("arst_nen",  64'(noise_en), 64'(0));
      chk("arst_freq", 64'(cfg_freq), 64'(0));
      chk("arst_step", 64'(step),     64'(0));
      @(negedge clk);
      reset = 1'b0;

      for (int r = 0; r < 8; r++)
         do_run(int'($urandom_range(20, 0)), int'($urandom_range(3, 1)), 3, -1, 1'b1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
